// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, derived
// address-field widths and helpers that slice a fetch address into
// tag / index / word-select fields.
package inst_cache_pkg;

    typedef logic [0:0] cacheState_t;

    localparam cacheState_t ST_IDLE = 1'b0;
    localparam cacheState_t ST_FILL = 1'b1;

    // Byte-offset bits covered by one line (word select plus byte lanes).
    function automatic int offBits(input int lineWords);
        return $clog2(lineWords) + 2;
    endfunction

    // Index bits needed to address every line.
    function automatic int idxBits(input int numLines);
        return $clog2(numLines);
    endfunction

    // Whatever is left above offset and index is the tag.
    function automatic int tagBits(input int addrW, input int lineWords, input int numLines);
        return addrW - offBits(lineWords) - idxBits(numLines);
    endfunction

    // Generic field extractor; callers size-cast the result to the field width.
    function automatic logic [63:0] addrField(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] fieldIndex(input logic [63:0] addr, input int lineWords,
                                               input int numLines);
        return addrField(addr, offBits(lineWords), idxBits(numLines));
    endfunction

    function automatic logic [63:0] fieldTag(input logic [63:0] addr, input int addrW,
                                             input int lineWords, input int numLines);
        return addrField(addr, offBits(lineWords) + idxBits(numLines),
                         tagBits(addrW, lineWords, numLines));
    endfunction

    function automatic logic [63:0] fieldWord(input logic [63:0] addr, input int lineWords);
        return addrField(addr, 2, $clog2(lineWords));
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-port and memory-port signals of the instruction cache. The cache
// sits on the slave side; the CPU fetch stage and memory sit on the master side.
interface inst_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_chipEnable;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic [DATA_W-1:0] o_inst;
    logic              o_instValid;
    logic              o_stall;
    logic              o_memReq;
    logic [ADDR_W-1:0] o_memAddr;
    logic              i_memAck;
    logic [DATA_W-1:0] i_memData;

    modport slave (
        input  i_chipEnable, i_addr, i_flush, i_memAck, i_memData,
        output o_inst, o_instValid, o_stall, o_memReq, o_memAddr
    );

    modport master (
        output i_chipEnable, i_addr, i_flush, i_memAck, i_memData,
        input  o_inst, o_instValid, o_stall, o_memReq, o_memAddr
    );
endinterface

// File: rtl/inst_cache_data_ram.sv
// Line data storage: one synchronous write port used by the line fill and
// one asynchronous read port so hits return in the same cycle.
module inst_cache_data_ram #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
)(
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(NUM_LINES)-1:0] wrLine,
    input  logic [$clog2(LINE_WORDS)-1:0] wrWord,
    input  logic [DATA_W-1:0]            wrData,
    input  logic [$clog2(NUM_LINES)-1:0] rdLine,
    input  logic [$clog2(LINE_WORDS)-1:0] rdWord,
    output logic [DATA_W-1:0]            rdData
);
    localparam int DEPTH = NUM_LINES * LINE_WORDS;

    logic [DATA_W-1:0] mem [DEPTH];

    // Fill writes one word per accepted memory beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wrLine, wrWord}] <= wrData;
        end
    end

    assign rdData = mem[{rdLine, rdWord}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Hits are answered
// combinationally; a miss stalls the fetch stage while a whole line is
// pulled from external memory one word per acknowledge.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
)(
    input  logic       clk,
    input  logic       rst,
    inst_cache_if.slave bus
);
    localparam int OFF    = offBits(LINE_WORDS);
    localparam int IDX    = idxBits(NUM_LINES);
    localparam int TAG_W  = tagBits(ADDR_W, LINE_WORDS, NUM_LINES);
    localparam int WSEL_W = OFF - 2;

    cacheState_t       stateReg;
    cacheState_t       stateNext;
    logic [ADDR_W-1:0] fillBaseReg;
    logic [WSEL_W-1:0] wcntReg;
    logic              abortReg;

    logic [NUM_LINES-1:0] validVec;
    logic [TAG_W-1:0]     tagMem [NUM_LINES];

    logic [IDX-1:0]    lookIdx;
    logic [TAG_W-1:0]  lookTag;
    logic [WSEL_W-1:0] lookWord;
    logic [IDX-1:0]    fillIdx;
    logic [TAG_W-1:0]  fillTag;
    logic [DATA_W-1:0] ramRdData;

    logic hit;
    logic startFill;
    logic ackFill;
    logic lastAck;

    // Field split of the live fetch address and of the latched fill address.
    assign lookIdx  = IDX'(fieldIndex(64'(bus.i_addr), LINE_WORDS, NUM_LINES));
    assign lookTag  = TAG_W'(fieldTag(64'(bus.i_addr), ADDR_W, LINE_WORDS, NUM_LINES));
    assign lookWord = WSEL_W'(fieldWord(64'(bus.i_addr), LINE_WORDS));
    assign fillIdx  = IDX'(fieldIndex(64'(fillBaseReg), LINE_WORDS, NUM_LINES));
    assign fillTag  = TAG_W'(fieldTag(64'(fillBaseReg), ADDR_W, LINE_WORDS, NUM_LINES));

    // Lookups only succeed while idle; during a fill the line being
    // written may already be marked valid from its previous occupant.
    assign hit       = validVec[lookIdx] && (tagMem[lookIdx] == lookTag) && (stateReg == ST_IDLE);
    assign startFill = (stateReg == ST_IDLE) && bus.i_chipEnable && !hit && !bus.i_flush;
    assign ackFill   = (stateReg == ST_FILL) && bus.i_memAck;
    assign lastAck   = ackFill && (wcntReg == '1);

    assign bus.o_instValid = bus.i_chipEnable && hit;
    assign bus.o_stall     = bus.i_chipEnable && !hit;
    assign bus.o_inst      = bus.o_instValid ? ramRdData : '0;
    assign bus.o_memReq    = (stateReg == ST_FILL);
    assign bus.o_memAddr   = (stateReg == ST_FILL) ? (fillBaseReg + ADDR_W'({wcntReg, 2'b00})) : '0;

    // Next-state logic: start on an unsuppressed miss, finish on the last beat.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: if (startFill) stateNext = ST_FILL;
            ST_FILL: if (lastAck)   stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Fill control registers: state, latched line base, beat counter, abort flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= ST_IDLE;
            fillBaseReg <= '0;
            wcntReg     <= '0;
            abortReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (startFill) begin
                fillBaseReg <= {lookTag, lookIdx, {OFF{1'b0}}};
                wcntReg     <= '0;
                abortReg    <= 1'b0;
            end else if (ackFill) begin
                wcntReg <= wcntReg + WSEL_W'(1);
            end
            if (stateReg == ST_FILL) begin
                if (lastAck) begin
                    abortReg <= 1'b0;
                end else if (bus.i_flush) begin
                    abortReg <= 1'b1;
                end
            end
        end
    end

    // Per-line valid bits: flush clears everything, a clean fill sets its line.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            logic validBit;

            // A flush arriving together with the last beat still wins.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    validBit <= 1'b0;
                end else if (bus.i_flush) begin
                    validBit <= 1'b0;
                end else if (lastAck && !abortReg && (fillIdx == IDX'(gi))) begin
                    validBit <= 1'b1;
                end
            end

            assign validVec[gi] = validBit;
        end
    endgenerate

    // Tag store is written once per fill; an aborted fill leaves valid clear.
    always_ff @(posedge clk) begin
        if (lastAck) begin
            tagMem[fillIdx] <= fillTag;
        end
    end

    inst_cache_data_ram #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_dataRam (
        .clk    (clk),
        .we     (ackFill),
        .wrLine (fillIdx),
        .wrWord (wcntReg),
        .wrData (bus.i_memData),
        .rdLine (lookIdx),
        .rdWord (lookWord),
        .rdData (ramRdData)
    );

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a behavioural memory answers fill requests
// with a programmable number of wait states; each scenario task checks its
// own expected values.
module tb_inst_cache;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    inst_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_cache #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .LINE_WORDS (4),
        .NUM_LINES  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passCount  = 0;
    int checkCount = 0;

    // Memory model state
    int          ackDelay    = 0;
    int          waitCnt     = 0;
    int          stableViol  = 0;
    logic        prevWaiting = 1'b0;
    logic [31:0] prevAddr    = '0;
    logic [31:0] ackAddrs [$];

    // Memory contents: line 0x000 holds A0..A3, line 0x100 holds B0..B3,
    // everything else returns its own address tagged with C in the top nibble.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[31:4] == 28'h0)
            return 32'hA0 + 32'(a[3:2]);
        else if (a[31:4] == 28'h10)
            return 32'hB0 + 32'(a[3:2]);
        else
            return 32'hC000_0000 | a;
    endfunction

    // Memory responder: acks after ackDelay idle cycles, one word per ack.
    initial begin
        bus.i_memAck  = 1'b0;
        bus.i_memData = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && bus.o_memReq === 1'b1) begin
                if (prevWaiting && bus.o_memAddr !== prevAddr) stableViol++;
                if (waitCnt >= ackDelay) begin
                    bus.i_memAck  = 1'b1;
                    bus.i_memData = memWord(bus.o_memAddr);
                    ackAddrs.push_back(bus.o_memAddr);
                    $display("mem ack addr=%08h data=%08h t=%0t", bus.o_memAddr, bus.i_memData, $time);
                    waitCnt     = 0;
                    prevWaiting = 1'b0;
                end else begin
                    bus.i_memAck  = 1'b0;
                    bus.i_memData = '0;
                    waitCnt++;
                    prevWaiting = 1'b1;
                    prevAddr    = bus.o_memAddr;
                end
            end else begin
                bus.i_memAck  = 1'b0;
                bus.i_memData = '0;
                waitCnt       = 0;
                prevWaiting   = 1'b0;
            end
        end
    end

    // Advance to a point well after the edge; inputs are driven from here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Present a fetch and wait until the stall drops; returns stalled cycles.
    task automatic runFetch(input logic [31:0] addr, output int stalls);
        cyc();
        bus.i_chipEnable = 1'b1;
        bus.i_addr       = addr;
        #1;
        stalls = 0;
        while (bus.o_stall === 1'b1 && stalls < 100) begin
            stalls++;
            cyc();
            #1;
        end
        $display("fetch addr=%08h stalls=%0d inst=%08h valid=%0b", addr, stalls, bus.o_inst, bus.o_instValid);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        #1;
        checkCount++;
        if (bus.o_memReq !== 1'b0) $display("FAIL reset_memReq: got %0b want 0", bus.o_memReq);
        else passCount++;
        checkCount++;
        if (bus.o_memAddr !== 32'h0) $display("FAIL reset_memAddr: got %08h want 0", bus.o_memAddr);
        else passCount++;
        checkCount++;
        if (bus.o_stall !== 1'b0) $display("FAIL reset_stall_ce0: got %0b want 0", bus.o_stall);
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'h0) $display("FAIL reset_inst: got %08h want 0", bus.o_inst);
        else passCount++;
        bus.i_chipEnable = 1'b1;
        bus.i_addr       = 32'h0;
        #1;
        checkCount++;
        if (bus.o_stall !== 1'b1) $display("FAIL reset_stall_ce1: got %0b want 1", bus.o_stall);
        else passCount++;
        bus.i_chipEnable = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_cold_miss();
        int st;
        logic [31:0] got;
        ackDelay = 0;
        ackAddrs.delete();
        runFetch(32'h0000_0000, st);
        checkCount++;
        if (st !== 5) $display("FAIL cold_stall_cycles: got %0d want 5", st);
        else passCount++;
        checkCount++;
        if (bus.o_instValid !== 1'b1) $display("FAIL cold_instValid: got %0b want 1", bus.o_instValid);
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'hA0) $display("FAIL cold_inst: got %08h want 000000a0", bus.o_inst);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            got = (i < ackAddrs.size()) ? ackAddrs[i] : 32'hFFFF_FFFF;
            checkCount++;
            if (got !== 32'(i * 4)) $display("FAIL cold_memAddr%0d: got %08h want %08h", i, got, 32'(i * 4));
            else passCount++;
        end
        cyc();
        bus.i_addr = 32'h0000_000C;
        #1;
        checkCount++;
        if (bus.o_inst !== 32'hA3) $display("FAIL cold_word3_inst: got %08h want 000000a3", bus.o_inst);
        else passCount++;
        checkCount++;
        if (bus.o_memReq !== 1'b0) $display("FAIL cold_word3_memReq: got %0b want 0", bus.o_memReq);
        else passCount++;
    endtask

    task automatic test_conflict();
        int st;
        ackAddrs.delete();
        runFetch(32'h0000_0100, st);
        checkCount++;
        if (st !== 5) $display("FAIL conflict_stall_cycles: got %0d want 5", st);
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'hB0) $display("FAIL conflict_inst: got %08h want 000000b0", bus.o_inst);
        else passCount++;
        checkCount++;
        if (ackAddrs.size() != 4 || ackAddrs[0] !== 32'h100 || ackAddrs[3] !== 32'h10C)
            $display("FAIL conflict_addrs: got n=%0d first=%08h want n=4 first=00000100 last=0000010c",
                     ackAddrs.size(), (ackAddrs.size() > 0) ? ackAddrs[0] : 32'hFFFF_FFFF);
        else passCount++;
        runFetch(32'h0000_0000, st);
        checkCount++;
        if (st !== 5) $display("FAIL conflict_refetch_stall: got %0d want 5", st);
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'hA0) $display("FAIL conflict_refetch_inst: got %08h want 000000a0", bus.o_inst);
        else passCount++;
    endtask

    task automatic test_wait_states();
        int st;
        ackDelay   = 3;
        stableViol = 0;
        ackAddrs.delete();
        runFetch(32'h0000_0208, st);
        ackDelay = 0;
        checkCount++;
        if (st !== 17) $display("FAIL wait_stall_cycles: got %0d want 17", st);
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'hC000_0208) $display("FAIL wait_inst: got %08h want c0000208", bus.o_inst);
        else passCount++;
        checkCount++;
        if (stableViol !== 0) $display("FAIL wait_addr_stable: got %0d changes want 0", stableViol);
        else passCount++;
        checkCount++;
        if (ackAddrs.size() != 4 || ackAddrs[0] !== 32'h200)
            $display("FAIL wait_acks: got n=%0d want n=4 first=00000200", ackAddrs.size());
        else passCount++;
    endtask

    task automatic test_flush();
        int n;
        ackAddrs.delete();
        cyc();
        bus.i_chipEnable = 1'b1;
        bus.i_addr       = 32'h0000_0040;
        #1;
        n = 0;
        while (bus.o_stall === 1'b1 && n < 100) begin
            n++;
            cyc();
            bus.i_flush = (n == 2);
            #1;
        end
        bus.i_flush = 1'b0;
        $display("flush-during-fill addr=00000040 stalls=%0d acks=%0d", n, ackAddrs.size());
        checkCount++;
        if (n !== 10) $display("FAIL flushfill_stall_cycles: got %0d want 10", n);
        else passCount++;
        checkCount++;
        if (ackAddrs.size() != 8 || ackAddrs[4] !== 32'h40)
            $display("FAIL flushfill_refetch: got n=%0d want n=8 with refetch of 00000040", ackAddrs.size());
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'hC000_0040) $display("FAIL flushfill_inst: got %08h want c0000040", bus.o_inst);
        else passCount++;

        // Flush while idle
        cyc();
        bus.i_addr = 32'h0000_0044;
        #1;
        checkCount++;
        if (bus.o_inst !== 32'hC000_0044) $display("FAIL idleflush_prehit: got %08h want c0000044", bus.o_inst);
        else passCount++;
        cyc();
        bus.i_flush = 1'b1;
        #1;
        checkCount++;
        if (bus.o_instValid !== 1'b1) $display("FAIL idleflush_samecycle_hit: got %0b want 1", bus.o_instValid);
        else passCount++;
        cyc();
        bus.i_addr = 32'h0000_0300;
        #1;
        checkCount++;
        if (bus.o_stall !== 1'b1) $display("FAIL idleflush_miss_stall: got %0b want 1", bus.o_stall);
        else passCount++;
        cyc();
        bus.i_flush = 1'b0;
        bus.i_addr  = 32'h0000_0044;
        #1;
        checkCount++;
        if (bus.o_memReq !== 1'b0) $display("FAIL idleflush_fill_suppressed: got memReq %0b want 0", bus.o_memReq);
        else passCount++;
        checkCount++;
        if (bus.o_stall !== 1'b1) $display("FAIL idleflush_line_invalid: got stall %0b want 1", bus.o_stall);
        else passCount++;
        n = 0;
        while (bus.o_stall === 1'b1 && n < 100) begin
            n++;
            cyc();
            #1;
        end
        checkCount++;
        if (n !== 5) $display("FAIL idleflush_refill_stall: got %0d want 5", n);
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'hC000_0044) $display("FAIL idleflush_refill_inst: got %08h want c0000044", bus.o_inst);
        else passCount++;
    endtask

    task automatic test_reset_mid_fill();
        int st;
        int n;
        runFetch(32'h0000_0000, st);
        checkCount++;
        if (bus.o_inst !== 32'hA0) $display("FAIL rstfill_preload: got %08h want 000000a0", bus.o_inst);
        else passCount++;
        ackAddrs.delete();
        cyc();
        bus.i_addr = 32'h0000_0300;
        #1;
        n = 0;
        while (ackAddrs.size() < 2 && n < 100) begin
            n++;
            cyc();
            #1;
        end
        checkCount++;
        if (ackAddrs.size() < 2) $display("FAIL rstfill_acks: got %0d acks want 2", ackAddrs.size());
        else passCount++;
        rst = 1'b0;
        #1;
        checkCount++;
        if (bus.o_memReq !== 1'b0) $display("FAIL rstfill_memReq_drop: got %0b want 0", bus.o_memReq);
        else passCount++;
        checkCount++;
        if (bus.o_memAddr !== 32'h0) $display("FAIL rstfill_memAddr: got %08h want 0", bus.o_memAddr);
        else passCount++;
        bus.i_chipEnable = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        runFetch(32'h0000_0000, st);
        checkCount++;
        if (st !== 5) $display("FAIL rstfill_valid_cleared: got %0d stalls want 5", st);
        else passCount++;
        checkCount++;
        if (bus.o_inst !== 32'hA0) $display("FAIL rstfill_refetch_inst: got %08h want 000000a0", bus.o_inst);
        else passCount++;
    endtask

    task automatic test_disabled();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h0000_0500;
        addrs[2] = 32'h0000_010C;
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.i_chipEnable = 1'b0;
            bus.i_addr       = addrs[i];
            #1;
            $display("disabled addr=%08h stall=%0b valid=%0b inst=%08h req=%0b",
                     addrs[i], bus.o_stall, bus.o_instValid, bus.o_inst, bus.o_memReq);
            checkCount++;
            if (bus.o_stall !== 1'b0) $display("FAIL disabled_stall%0d: got %0b want 0", i, bus.o_stall);
            else passCount++;
            checkCount++;
            if (bus.o_instValid !== 1'b0) $display("FAIL disabled_valid%0d: got %0b want 0", i, bus.o_instValid);
            else passCount++;
            checkCount++;
            if (bus.o_inst !== 32'h0) $display("FAIL disabled_inst%0d: got %08h want 0", i, bus.o_inst);
            else passCount++;
            checkCount++;
            if (bus.o_memReq !== 1'b0) $display("FAIL disabled_memReq%0d: got %0b want 0", i, bus.o_memReq);
            else passCount++;
        end
        cyc();
        #1;
        checkCount++;
        if (bus.o_memReq !== 1'b0) $display("FAIL disabled_no_fill: got memReq %0b want 0", bus.o_memReq);
        else passCount++;
    endtask

    initial begin
        bus.i_chipEnable = 1'b0;
        bus.i_addr       = '0;
        bus.i_flush      = 1'b0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_wait_states();
        test_flush();
        test_reset_mid_fill();
        test_disabled();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC address plus chip enable) and a slower external instruction memory with a req/ack handshake.
- Hits return the instruction combinationally in the same cycle. A miss raises a stall and runs a line fill, one word per memory acknowledge.
- Lets the pipeline fetch from a multi-cycle ROM and replaces the zero-latency ROM connection.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, instruction/word width
- LINE_WORDS, 4, words per line (power of 2, at least 2)
- NUM_LINES, 16, lines in cache (power of 2, at least 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_chipEnable  in  1  fetch request from PC stage
- i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- i_flush  in  1  invalidate all lines
- o_inst  out  DATA_W  fetched instruction
- o_instValid  out  1  o_inst valid this cycle
- o_stall  out  1  fetch cannot complete; PC must hold
- o_memReq  out  1  external memory word request
- o_memAddr  out  ADDR_W  word-aligned request address
- i_memAck  in  1  memory accepts the request; i_memData valid this cycle
- i_memData  in  DATA_W  returned word

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS)+2 (16 lines x 4 words gives OFF=4).
  - index = i_addr[OFF+IDX-1:OFF], with IDX = log2(NUM_LINES).
  - tag = i_addr[ADDR_W-1:OFF+IDX].
  - word select = i_addr[OFF-1:2].
- Storage: per line a valid bit, a tag, and LINE_WORDS data words.
- Hit = valid[index] && tag match && state==IDLE. Evaluated combinationally.
- Outputs (combinational):
  - o_instValid = i_chipEnable && hit.
  - o_stall = i_chipEnable && !hit.
  - o_inst = selected word when o_instValid, else 0.
- FSM states IDLE and FILL.
- IDLE → FILL when i_chipEnable && !hit && !i_flush. On entry, latch fill_base = {tag,index,0...} and set wcnt=0.
- FILL:
  - o_memReq=1 and o_memAddr = fill_base + 4*wcnt, both held stable until i_memAck is sampled high.
  - On ack, write i_memData into word wcnt and increment wcnt.
  - Back-to-back acks are legal; the address advances the following cycle.
  - On the ack of word LINE_WORDS-1: write tag, set valid (unless aborted), return to IDLE.
  - The first hit is visible the cycle after the last ack. Minimum miss penalty is LINE_WORDS+1 cycles.
- o_memReq=0 and o_memAddr=0 in IDLE.
- Changes to i_addr or i_chipEnable during FILL do not affect the fill. The latched line completes, then lookup resumes with the current i_addr.
- i_chipEnable=0 in IDLE: o_inst=0, o_instValid=0, o_stall=0, no fill started.
- i_flush:
  - All valid bits clear at the next edge. An output hit in the same cycle is still reported.
  - In IDLE, a flush suppresses any miss-triggered fill that cycle.
  - In FILL, the fill runs to completion with handshakes honoured, but valid is not set (abort flag).
  - An abort flag set in FILL clears on return to IDLE.
- Reset (asynchronous assertion): state=IDLE, all valid=0, wcnt=0, abort=0, o_memReq=0, o_memAddr=0. Data and tag arrays are not reset.
- Reset mid-fill: o_memReq drops immediately. The memory side must tolerate the abandoned request.
- A late i_memAck outside FILL is ignored.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, FILL);
  - derived widths OFF, IDX, TAG_W as functions of the parameters;
  - the cache address-field slice helpers.
- One natural sub-module: inst_cache_data_ram.
  - NUM_LINES*LINE_WORDS x DATA_W array.
  - Synchronous write port (line, word, data, we) and an asynchronous read port (line, word).
  - Tag and valid arrays stay in inst_cache.

Test Plan:
- Cold miss with fast memory:
  - Stimulus: release reset, chipEnable=1, addr 0x00000000; memory acks every cycle with data 0xA0..0xA3.
  - Response: o_stall=1 for 5 cycles; o_memAddr sequence 0x00, 0x04, 0x08, 0x0C; then o_instValid=1, o_inst=0xA0.
  - Follow-up: addr 0x0C in the next cycle gives o_inst=0xA3 the same cycle with o_memReq=0.
- Conflict miss:
  - Stimulus: after the line at 0x000, fetch 0x100 (index 0, tag 1); data 0xB0..0xB3.
  - Response: refill from 0x100–0x10C and o_inst=0xB0. Re-fetching 0x000 misses again and refills 0xA0..0xA3.
- Wait states: each ack delayed 3 cycles → o_memAddr stable while waiting; fill completes in 4*4+1 cycles; o_inst correct.
- Flush during fill:
  - Stimulus: pulse i_flush at word 1 of the fill of 0x040.
  - Response: fill completes with 4 acks; the next cycle still misses on 0x040 and refetches. A separate flush in IDLE makes a previously hit line miss.
- Reset mid-fill: drive rst low after 2 acks → o_memReq=0 in the same cycle; after release, fetch 0x000 misses (valid cleared).
- Disabled fetch: chipEnable=0 with any addr → o_stall=0, o_instValid=0, o_inst=0, no o_memReq.
